// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings,
// PC step and default table geometry.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } ctr_e;

    localparam logic [31:0] PC_INC         = 32'd4;
    localparam int          DEF_INDEX_BITS = 6;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter next-value function.
// Counts up on taken, down on not-taken, clamping at both ends.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != STRONG_T) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != STRONG_NT) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and debug counters.
// Lookup is combinational; training lands on the next clock edge.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         INDEX_BITS   = DEF_INDEX_BITS,
    parameter logic [1:0] COUNTER_INIT = WEAK_NT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_pc,
    output logic        btb_hit,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] fidx;
    logic [TAG_W-1:0]      ftag;
    logic [INDEX_BITS-1:0] uidx;
    logic [TAG_W-1:0]      utag;
    logic                  uhit;
    logic [1:0]            ctr_nxt;

    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{fetch_pc[1:0], update_pc[1:0]};

    assign fidx = fetch_pc[INDEX_BITS+1:2];
    assign ftag = fetch_pc[31:INDEX_BITS+2];
    assign uidx = update_pc[INDEX_BITS+1:2];
    assign utag = update_pc[31:INDEX_BITS+2];

    assign btb_hit       = valid_q[fidx] && (tag_q[fidx] == ftag);
    assign predict_taken = btb_hit && ctr_q[fidx][1];
    assign predict_pc    = predict_taken ? target_q[fidx]
                                         : fetch_pc + PC_INC;

    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    sat_counter2 u_ctr (
        .ctr_i (ctr_q[uidx]),
        .inc_i (update_taken),
        .ctr_o (ctr_nxt)
    );

    // Read-before-write: table changes only at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= COUNTER_INIT;
            end
        end else if (update_valid) begin
            if (uhit) begin
                ctr_q[uidx] <= ctr_nxt;
                if (update_taken) begin
                    target_q[uidx] <= update_target;
                end
            end else if (update_taken) begin
                valid_q[uidx]  <= 1'b1;
                tag_q[uidx]    <= utag;
                target_q[uidx] <= update_target;
                ctr_q[uidx]    <= WEAK_T;
            end
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (update_valid) begin
            if (br_cnt_q != 32'hFFFF_FFFF) begin
                br_cnt_d = br_cnt_q + 32'd1;
            end
            if (update_mispredict && mis_cnt_q != 32'hFFFF_FFFF) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign branch_count     = br_cnt_q;
    assign mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against
// an array-based reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic        btb_hit;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_pc          (fetch_pc),
        .predict_taken     (predict_taken),
        .predict_pc        (predict_pc),
        .btb_hit           (btb_hit),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    always #5 clk = ~clk;

    localparam int     NENT = 64;
    localparam longint CMAX = 64'hFFFF_FFFF;

    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    longint      m_bc;
    longint      m_mc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc >> 8;
    endfunction

    task automatic check_model();
        int    i;
        bit    hit;
        bit    tk;
        logic [31:0] npc;
        i   = idx_of(fetch_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(fetch_pc));
        tk  = hit && (m_ctr[i] >= 2);
        npc = tk ? m_tgt[i] : fetch_pc + 32'd4;
        check("hit", {31'd0, btb_hit}, {31'd0, hit});
        check("taken", {31'd0, predict_taken}, {31'd0, tk});
        check("ppc", predict_pc, npc);
        check("bcnt", branch_count, m_bc[31:0]);
        check("mcnt", mispredict_count, m_mc[31:0]);
    endtask

    task automatic model_edge();
        int i;
        if (reset) begin
            for (int k = 0; k < NENT; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_bc = 0;
            m_mc = 0;
        end else if (update_valid) begin
            m_bc = (m_bc + 1 > CMAX) ? CMAX : m_bc + 1;
            if (update_mispredict) begin
                m_mc = (m_mc + 1 > CMAX) ? CMAX : m_mc + 1;
            end
            i = idx_of(update_pc);
            if (m_valid[i] && m_tag[i] == tag_of(update_pc)) begin
                if (update_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = update_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (update_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(update_pc);
                m_tgt[i]   = update_target;
                m_ctr[i]   = 2;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic upd(logic [31:0] pc, logic tk, logic [31:0] tgt,
                       logic mis);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = tk;
        update_target     = tgt;
        update_mispredict = mis;
        cycle();
        update_valid = 1'b0;
    endtask

    task automatic look(string tag, logic [31:0] pc, logic h, logic t,
                        logic [31:0] npc);
        fetch_pc = pc;
        #1;
        check({tag, "_hit"}, {31'd0, btb_hit}, {31'd0, h});
        check({tag, "_tk"}, {31'd0, predict_taken}, {31'd0, t});
        check({tag, "_ppc"}, predict_pc, npc);
    endtask

    logic [31:0] pool [8];

    initial begin
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_0200;
        pool[2] = 32'h0000_0104;
        pool[3] = 32'h1000_0104;
        pool[4] = 32'h0000_0008;
        pool[5] = 32'hFFFF_FFFC;
        pool[6] = 32'h0000_0300;
        pool[7] = 32'h0000_010C;

        reset             = 1'b1;
        fetch_pc          = 32'h100;
        update_valid      = 1'b0;
        update_pc         = 32'h0;
        update_taken      = 1'b0;
        update_target     = 32'h0;
        update_mispredict = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        reset = 1'b0;

        look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        check("rst_bcnt", branch_count, 32'd0);
        check("rst_mcnt", mispredict_count, 32'd0);

        upd(32'h100, 1'b1, 32'h40, 1'b1);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h40);
        check("alloc_bcnt", branch_count, 32'd1);

        upd(32'h100, 1'b0, 32'h0, 1'b1);
        upd(32'h100, 1'b0, 32'h0, 1'b1);
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);

        for (int k = 0; k < 4; k++) upd(32'h100, 1'b1, 32'h40, 1'b0);
        look("sat3", 32'h100, 1'b1, 1'b1, 32'h40);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("dec1", 32'h100, 1'b1, 1'b1, 32'h40);

        upd(32'h200, 1'b1, 32'h80, 1'b1);
        look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        look("alias_new", 32'h200, 1'b1, 1'b1, 32'h80);

        fetch_pc          = 32'h300;
        update_valid      = 1'b1;
        update_pc         = 32'h300;
        update_taken      = 1'b1;
        update_target     = 32'h1234;
        update_mispredict = 1'b0;
        #1;
        check("rbw_same", predict_pc, 32'h304);
        cycle();
        update_valid = 1'b0;
        look("rbw_next", 32'h300, 1'b1, 1'b1, 32'h1234);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            reset             = ($urandom_range(0, 299) == 0);
            fetch_pc          = pool[$urandom_range(0, 7)];
            update_valid      = $urandom_range(0, 3) != 0;
            update_pc         = pool[$urandom_range(0, 7)];
            update_taken      = $urandom_range(0, 1) == 1;
            update_target     = $urandom & 32'hFFFF_FFFC;
            update_mispredict = $urandom_range(0, 1) == 1;
            cycle();
        end
        reset        = 1'b0;
        update_valid = 1'b0;

        force dut.mis_cnt_q = 32'hFFFF_FFFE;
        force dut.br_cnt_q  = 32'hFFFF_FFFD;
        #1;
        release dut.mis_cnt_q;
        release dut.br_cnt_q;
        m_mc = 64'hFFFF_FFFE;
        m_bc = 64'hFFFF_FFFD;
        for (int k = 0; k < 3; k++) upd(32'h8, 1'b1, 32'h500, 1'b1);
        check("msat", mispredict_count, 32'hFFFF_FFFF);
        check("bsat", branch_count, 32'hFFFF_FFFF);

        reset             = 1'b1;
        update_valid      = 1'b1;
        update_pc         = 32'h100;
        update_taken      = 1'b1;
        update_target     = 32'h40;
        update_mispredict = 1'b1;
        cycle();
        reset        = 1'b0;
        update_valid = 1'b0;
        look("rst_upd8", 32'h8, 1'b0, 1'b0, 32'hC);
        look("rst_upd100", 32'h100, 1'b0, 1'b0, 32'h104);
        check("rst_upd_bcnt", branch_count, 32'd0);
        check("rst_upd_mcnt", mispredict_count, 32'd0);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
